// File: rtl/mem_arbiter_if.sv
// Bundles the instruction, data and shared-memory ports of the arbiter.
// The slave modport is the arbiter's side; the master modport is the requesters' and memory's side.
interface mem_arbiter_if;
    logic [31:0] i_address;
    logic        i_read_enable;
    logic [31:0] i_read_data;
    logic        i_read_valid;

    logic [31:0] d_address;
    logic        d_read_enable;
    logic        d_write_enable;
    logic [31:0] d_write_data;
    logic [3:0]  d_write_wstrb;
    logic [31:0] d_read_data;
    logic        d_read_valid;
    logic        d_write_ready;

    logic [31:0] m_address;
    logic        m_read_enable;
    logic        m_write_enable;
    logic [31:0] m_write_data;
    logic [3:0]  m_write_wstrb;
    logic [31:0] m_read_data;
    logic        m_read_valid;
    logic        m_write_ready;

    logic        grant_data;
    logic        bus_error;

    modport slave (
        input  i_address, i_read_enable,
        output i_read_data, i_read_valid,
        input  d_address, d_read_enable, d_write_enable, d_write_data, d_write_wstrb,
        output d_read_data, d_read_valid, d_write_ready,
        output m_address, m_read_enable, m_write_enable, m_write_data, m_write_wstrb,
        input  m_read_data, m_read_valid, m_write_ready,
        output grant_data, bus_error
    );

    modport master (
        output i_address, i_read_enable,
        input  i_read_data, i_read_valid,
        output d_address, d_read_enable, d_write_enable, d_write_data, d_write_wstrb,
        input  d_read_data, d_read_valid, d_write_ready,
        input  m_address, m_read_enable, m_write_enable, m_write_data, m_write_wstrb,
        output m_read_data, m_read_valid, m_write_ready,
        input  grant_data, bus_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto one memory port, one transaction outstanding.
// Latency: request edge -> memory enable next cycle; same-cycle memory response -> requester valid 2 cycles after request.
// Backpressure: memory stalls hold the BUSY state (bounded by TIMEOUT); requesters hold their enables until the response edge.
module mem_arbiter #(
    parameter bit PRIORITY_DATA = 1'b1,
    parameter int TIMEOUT       = 255
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;
    logic [3:0]  wstrb_q;
    logic        wr_q, owner_d_q, last_d_q, err_q;
    logic [7:0]  wait_cnt;

    logic        i_req, d_req, busy;
    logic        grant_any, grant_d, done, timeout;

    assign i_req = bus.i_read_enable;
    assign d_req = bus.d_read_enable | bus.d_write_enable;
    assign busy  = (state == BUSY_I) || (state == BUSY_D);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_any = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_any = 1'b1;
                    if (i_req && d_req) grant_d = PRIORITY_DATA ? 1'b1 : !last_d_q;
                    else                grant_d = d_req;
                    state_nxt = grant_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                done    = wr_q ? bus.m_write_ready : bus.m_read_valid;
                timeout = !done && (TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT);
                if (done || timeout) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_q      <= 1'b0;
            owner_d_q <= 1'b0;
            last_d_q  <= 1'b0;
            err_q     <= 1'b0;
            wait_cnt  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant_any) begin
                // A simultaneous read+write from the data port is treated as a write only.
                addr_q    <= grant_d ? bus.d_address : bus.i_address;
                wr_q      <= grant_d & bus.d_write_enable;
                wdata_q   <= grant_d ? bus.d_write_data : '0;
                wstrb_q   <= grant_d ? bus.d_write_wstrb : '0;
                owner_d_q <= grant_d;
                last_d_q  <= grant_d;
                wait_cnt  <= '0;
                err_q     <= 1'b0;
            end
            if (busy) begin
                if (done || timeout) begin
                    err_q <= timeout;
                    if (!wr_q) begin
                        if (owner_d_q) d_rdata_q <= done ? bus.m_read_data : '0;
                        else           i_rdata_q <= done ? bus.m_read_data : '0;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.m_address      = addr_q;
    assign bus.m_write_data   = wdata_q;
    assign bus.m_write_wstrb  = wstrb_q;
    assign bus.m_read_enable  = busy & !wr_q;
    assign bus.m_write_enable = busy & wr_q;

    assign bus.i_read_data    = i_rdata_q;
    assign bus.i_read_valid   = (state == RESP) & !owner_d_q;
    assign bus.d_read_data    = d_rdata_q;
    assign bus.d_read_valid   = (state == RESP) & owner_d_q & !wr_q;
    assign bus.d_write_ready  = (state == RESP) & owner_d_q & wr_q;

    assign bus.grant_data     = (state == BUSY_D) || ((state == RESP) && owner_d_q);
    assign bus.bus_error      = (state == RESP) & err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one fixed-priority instance and one round-robin instance, both with TIMEOUT=4.
module tb_mem_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_arbiter_if ifp ();
    mem_arbiter_if ifr ();

    mem_arbiter #(.PRIORITY_DATA(1'b1), .TIMEOUT(4)) dut_pd (.clk(clk), .reset(reset), .bus(ifp.slave));
    mem_arbiter #(.PRIORITY_DATA(1'b0), .TIMEOUT(4)) dut_rr (.clk(clk), .reset(reset), .bus(ifr.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifp.i_address = '0; ifp.i_read_enable = 0; ifp.d_address = '0; ifp.d_read_enable = 0;
        ifp.d_write_enable = 0; ifp.d_write_data = '0; ifp.d_write_wstrb = '0;
        ifp.m_read_data = '0; ifp.m_read_valid = 0; ifp.m_write_ready = 0;
        ifr.i_address = '0; ifr.i_read_enable = 0; ifr.d_address = '0; ifr.d_read_enable = 0;
        ifr.d_write_enable = 0; ifr.d_write_data = '0; ifr.d_write_wstrb = '0;
        ifr.m_read_data = '0; ifr.m_read_valid = 0; ifr.m_write_ready = 0;
    endtask

    task automatic test_reset();
        logic [138:0] op, orr;
        tick(); tick();
        op  = {ifp.i_read_data, ifp.i_read_valid, ifp.d_read_data, ifp.d_read_valid, ifp.d_write_ready,
               ifp.m_address, ifp.m_read_enable, ifp.m_write_enable, ifp.m_write_data, ifp.m_write_wstrb,
               ifp.grant_data, ifp.bus_error};
        orr = {ifr.i_read_data, ifr.i_read_valid, ifr.d_read_data, ifr.d_read_valid, ifr.d_write_ready,
               ifr.m_address, ifr.m_read_enable, ifr.m_write_enable, ifr.m_write_data, ifr.m_write_wstrb,
               ifr.grant_data, ifr.bus_error};
        checks++;
        if (op !== '0) begin errors++; $display("FAIL reset_outputs_pd: got %h want 0", op); end
        checks++;
        if (orr !== '0) begin errors++; $display("FAIL reset_outputs_rr: got %h want 0", orr); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        ifp.i_read_enable = 1; ifp.i_address = 32'h100;
        tick();
        checks++;
        if ({ifp.m_read_enable, ifp.m_write_enable, ifp.grant_data} !== 3'b100 || ifp.m_address !== 32'h100) begin
            errors++; $display("FAIL fetch_issue: got re/we/gd=%b%b%b addr=%h want 100 addr=100",
                               ifp.m_read_enable, ifp.m_write_enable, ifp.grant_data, ifp.m_address);
        end
        ifp.m_read_valid = 1; ifp.m_read_data = 32'hDEADBEEF;
        tick();
        ifp.m_read_valid = 0; ifp.i_read_enable = 0;
        checks++;
        if (ifp.i_read_valid !== 1'b1 || ifp.i_read_data !== 32'hDEADBEEF || ifp.m_read_enable !== 1'b0) begin
            errors++; $display("FAIL fetch_resp: got v=%b data=%h re=%b want v=1 data=deadbeef re=0",
                               ifp.i_read_valid, ifp.i_read_data, ifp.m_read_enable);
        end
        tick();
        checks++;
        if (ifp.i_read_valid !== 1'b0 || ifp.i_read_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_hold: got v=%b data=%h want v=0 data=deadbeef",
                               ifp.i_read_valid, ifp.i_read_data);
        end
    endtask

    task automatic test_tie_priority();
        ifp.i_read_enable = 1; ifp.i_address = 32'h300;
        ifp.d_read_enable = 1; ifp.d_address = 32'h400;
        tick();
        checks++;
        if (ifp.grant_data !== 1'b1 || ifp.m_address !== 32'h400 || ifp.m_read_enable !== 1'b1) begin
            errors++; $display("FAIL tie_first_grant: got gd=%b addr=%h want gd=1 addr=400",
                               ifp.grant_data, ifp.m_address);
        end
        ifp.m_read_valid = 1; ifp.m_read_data = 32'hAAAA0001;
        tick();
        ifp.m_read_valid = 0; ifp.d_read_enable = 0;
        checks++;
        if ({ifp.d_read_valid, ifp.i_read_valid, ifp.grant_data} !== 3'b101 || ifp.d_read_data !== 32'hAAAA0001) begin
            errors++; $display("FAIL tie_d_resp: got dv/iv/gd=%b%b%b data=%h want 101 data=aaaa0001",
                               ifp.d_read_valid, ifp.i_read_valid, ifp.grant_data, ifp.d_read_data);
        end
        tick();
        checks++;
        if ({ifp.m_read_enable, ifp.d_read_valid, ifp.i_read_valid} !== 3'b000) begin
            errors++; $display("FAIL tie_idle: got re/dv/iv=%b%b%b want 000",
                               ifp.m_read_enable, ifp.d_read_valid, ifp.i_read_valid);
        end
        tick();
        checks++;
        if (ifp.grant_data !== 1'b0 || ifp.m_address !== 32'h300 || ifp.m_read_enable !== 1'b1) begin
            errors++; $display("FAIL tie_second_grant: got gd=%b addr=%h want gd=0 addr=300",
                               ifp.grant_data, ifp.m_address);
        end
        ifp.m_read_valid = 1; ifp.m_read_data = 32'hBBBB0002;
        tick();
        ifp.m_read_valid = 0; ifp.i_read_enable = 0;
        checks++;
        if ({ifp.i_read_valid, ifp.d_read_valid} !== 2'b10 || ifp.i_read_data !== 32'hBBBB0002
            || ifp.d_read_data !== 32'hAAAA0001) begin
            errors++; $display("FAIL tie_i_resp: got iv/dv=%b%b idata=%h ddata=%h want 10 bbbb0002 aaaa0001",
                               ifp.i_read_valid, ifp.d_read_valid, ifp.i_read_data, ifp.d_read_data);
        end
        tick();
    endtask

    task automatic test_write();
        ifp.d_write_enable = 1; ifp.d_address = 32'h200; ifp.d_write_data = 32'h12345678; ifp.d_write_wstrb = 4'b0011;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ifp.m_write_enable, ifp.m_read_enable, ifp.d_write_ready} !== 3'b100 || ifp.m_address !== 32'h200
                || ifp.m_write_data !== 32'h12345678 || ifp.m_write_wstrb !== 4'b0011) begin
                errors++; $display("FAIL write_hold_%0d: got we/re/wr=%b%b%b addr=%h data=%h strb=%b want 100 200 12345678 0011",
                                   k, ifp.m_write_enable, ifp.m_read_enable, ifp.d_write_ready,
                                   ifp.m_address, ifp.m_write_data, ifp.m_write_wstrb);
            end
            if (k == 2) ifp.m_write_ready = 1;
            tick();
        end
        ifp.m_write_ready = 0; ifp.d_write_enable = 0;
        checks++;
        if ({ifp.d_write_ready, ifp.d_read_valid, ifp.m_write_enable, ifp.grant_data} !== 4'b1001) begin
            errors++; $display("FAIL write_resp: got wr/dv/we/gd=%b%b%b%b want 1001",
                               ifp.d_write_ready, ifp.d_read_valid, ifp.m_write_enable, ifp.grant_data);
        end
        tick();
        checks++;
        if ({ifp.d_write_ready, ifp.grant_data} !== 2'b00) begin
            errors++; $display("FAIL write_done: got wr/gd=%b%b want 00", ifp.d_write_ready, ifp.grant_data);
        end
    endtask

    task automatic test_read_write_conflict();
        ifp.d_read_enable = 1; ifp.d_write_enable = 1; ifp.d_address = 32'h204;
        ifp.d_write_data = 32'hCAFEF00D; ifp.d_write_wstrb = 4'hF;
        tick();
        checks++;
        if ({ifp.m_read_enable, ifp.m_write_enable} !== 2'b01 || ifp.m_write_data !== 32'hCAFEF00D) begin
            errors++; $display("FAIL conflict_issue: got re/we=%b%b data=%h want 01 cafef00d",
                               ifp.m_read_enable, ifp.m_write_enable, ifp.m_write_data);
        end
        ifp.m_write_ready = 1; ifp.m_read_valid = 1; ifp.m_read_data = 32'h55555555;
        tick();
        clear_inputs();
        checks++;
        if ({ifp.d_read_valid, ifp.d_write_ready} !== 2'b01 || ifp.d_read_data !== 32'hAAAA0001) begin
            errors++; $display("FAIL conflict_resp: got dv/wr=%b%b ddata=%h want 01 aaaa0001",
                               ifp.d_read_valid, ifp.d_write_ready, ifp.d_read_data);
        end
        tick();
    endtask

    task automatic test_timeout();
        ifp.i_read_enable = 1; ifp.i_address = 32'h500;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({ifp.m_read_enable, ifp.bus_error, ifp.i_read_valid} !== 3'b100) begin
                errors++; $display("FAIL timeout_busy_%0d: got re/err/iv=%b%b%b want 100",
                                   k, ifp.m_read_enable, ifp.bus_error, ifp.i_read_valid);
            end
            tick();
        end
        ifp.i_read_enable = 0; ifp.m_read_valid = 1; ifp.m_read_data = 32'h77777777;
        checks++;
        if ({ifp.bus_error, ifp.i_read_valid, ifp.m_read_enable} !== 3'b110 || ifp.i_read_data !== 32'h0) begin
            errors++; $display("FAIL timeout_resp: got err/iv/re=%b%b%b data=%h want 110 data=0",
                               ifp.bus_error, ifp.i_read_valid, ifp.m_read_enable, ifp.i_read_data);
        end
        tick();
        ifp.m_read_valid = 0;
        checks++;
        if ({ifp.bus_error, ifp.i_read_valid, ifp.m_read_enable} !== 3'b000 || ifp.i_read_data !== 32'h0) begin
            errors++; $display("FAIL timeout_idle: got err/iv/re=%b%b%b data=%h want 000 data=0",
                               ifp.bus_error, ifp.i_read_valid, ifp.m_read_enable, ifp.i_read_data);
        end
    endtask

    task automatic test_round_robin();
        logic exp_d;
        ifr.i_read_enable = 1; ifr.i_address = 32'h10;
        ifr.d_read_enable = 1; ifr.d_address = 32'h20;
        for (int n = 0; n < 6; n++) begin
            int w = 0;
            while (ifr.m_read_enable !== 1'b1 && w < 6) begin tick(); w++; end
            checks++;
            if (ifr.m_read_enable !== 1'b1) begin
                errors++; $display("FAIL rr_wait_%0d: got re=%b after %0d cycles want 1", n, ifr.m_read_enable, w);
            end
            exp_d = (n % 2 == 0);
            checks++;
            if (ifr.grant_data !== exp_d || ifr.m_address !== (exp_d ? 32'h20 : 32'h10)) begin
                errors++; $display("FAIL rr_grant_%0d: got gd=%b addr=%h want gd=%b", n, ifr.grant_data, ifr.m_address, exp_d);
            end
            ifr.m_read_valid = 1; ifr.m_read_data = 32'hC0000000 + n;
            tick();
            ifr.m_read_valid = 0;
            checks++;
            if ({ifr.d_read_valid, ifr.i_read_valid} !== (exp_d ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr_resp_%0d: got dv/iv=%b%b want %b", n, ifr.d_read_valid, ifr.i_read_valid,
                                   exp_d ? 2'b10 : 2'b01);
            end
        end
        ifr.i_read_enable = 0; ifr.d_read_enable = 0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_busy();
        ifp.i_read_enable = 1; ifp.i_address = 32'h600;
        tick();
        checks++;
        if (ifp.m_read_enable !== 1'b1 || ifp.m_address !== 32'h600) begin
            errors++; $display("FAIL rst_mid_issue: got re=%b addr=%h want 1 600", ifp.m_read_enable, ifp.m_address);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({ifp.m_read_enable, ifp.i_read_valid, ifp.grant_data} !== 3'b000 || ifp.m_address !== 32'h0
            || ifp.d_read_data !== 32'h0) begin
            errors++; $display("FAIL rst_mid_async: got re/iv/gd=%b%b%b addr=%h ddata=%h want 000 0 0",
                               ifp.m_read_enable, ifp.i_read_valid, ifp.grant_data, ifp.m_address, ifp.d_read_data);
        end
        ifp.i_read_enable = 0;
        tick();
        reset = 1'b1;
        ifp.m_read_valid = 1; ifp.m_read_data = 32'h99999999;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({ifp.i_read_valid, ifp.m_read_enable} !== 2'b00 || ifp.i_read_data !== 32'h0) begin
                errors++; $display("FAIL rst_mid_after_%0d: got iv/re=%b%b data=%h want 00 0",
                                   k, ifp.i_read_valid, ifp.m_read_enable, ifp.i_read_data);
            end
        end
        ifp.m_read_valid = 0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_tie_priority();
        test_write();
        test_read_write_conflict();
        test_timeout();
        test_round_robin();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter PRIORITY_DATA, default 1: 1 gives fixed data-port priority on ties; 0 gives round-robin.
REQ-002 Parameter TIMEOUT, default 255: memory wait limit in cycles; 0 disables the timeout.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: one clock; reset is asynchronous and active-low (asserted at 0).
REQ-005 Ports i_address in 32, i_read_enable in 1, i_read_data out 32, i_read_valid out 1: instruction-fetch requester, read-only.
REQ-006 Ports d_address in 32, d_read_enable in 1, d_write_enable in 1, d_write_data in 32, d_write_wstrb in 4: data requester request fields.
REQ-007 Ports d_read_data out 32, d_read_valid out 1, d_write_ready out 1: data requester responses.
REQ-008 Ports m_address out 32, m_read_enable out 1, m_write_enable out 1, m_write_data out 32, m_write_wstrb out 4: shared memory port request.
REQ-009 Ports m_read_data in 32, m_read_valid in 1, m_write_ready in 1: shared memory port responses.
REQ-010 Ports grant_data out 1 (current owner is the data port) and bus_error out 1 (timeout pulse).

Function
REQ-011 FSM states: IDLE, BUSY_I, BUSY_D, RESP; exactly one transaction is outstanding at a time.
REQ-012 IDLE: sample the enables; i-only goes to BUSY_I; d-only goes to BUSY_D; no request stays in IDLE.
REQ-013 Tie with PRIORITY_DATA=1 goes to BUSY_D.
REQ-014 Tie with PRIORITY_DATA=0 grants the port not granted last; the last-grant flag resets to "instruction", so the first tie goes to data.
REQ-015 On the grant edge, latch address, op, write_data and wstrb into registers; m_* outputs come only from these registers.
REQ-016 During BUSY_*, drive m_read_enable or m_write_enable continuously, with stable m_address/m_write_data/m_write_wstrb, until completion.
REQ-017 Completion: m_read_valid=1 for a read, or m_write_ready=1 for a write, sampled at a rising edge in BUSY_*; m_read_data is captured on that edge.
REQ-018 RESP lasts exactly one cycle: m enables are 0; the owner's read_valid or write_ready is 1 with the captured data; next state is IDLE.
REQ-019 Non-owner response outputs stay 0 at all times; response data outputs hold their last value outside RESP.
REQ-020 Latency: a request sampled at edge t asserts m enable in cycle t+1. With a same-cycle memory response, the requester valid is in cycle t+2. Back-to-back throughput is one transaction per 3 cycles minimum.
REQ-021 Requester contract: hold the enable and fields stable until the response edge, and drop the enable at that edge unless issuing a new request.
REQ-022 If d_read_enable and d_write_enable are both 1, perform a write only; only d_write_ready is pulsed.
REQ-023 Wait counter (8 bits): clears on grant and increments each BUSY cycle without completion.
REQ-024 When TIMEOUT is nonzero and the counter reaches TIMEOUT, enter RESP with data 0 and pulse bus_error for that RESP cycle; a late memory response is ignored.
REQ-025 grant_data is 1 in BUSY_D and in RESP after a data transaction, and 0 otherwise.
REQ-026 Changes to a requester's inputs during another requester's BUSY have no effect until the next IDLE.

Reset
REQ-027 reset=0 immediately forces IDLE and sets every output to 0, including the data outputs, with no clock required.
REQ-028 reset=0 also clears the last-grant flag to "instruction" and the wait counter to 0.
REQ-029 Reset mid-transaction drops the transaction with no response pulse; the first request after release is treated as new.
REQ-030 Request sampling starts at the first rising edge with reset=1.

Verification
REQ-031 Single fetch: i_read_enable=1, i_address=0x100; memory returns 0xDEADBEEF next cycle -> i_read_valid=1 one cycle with 0xDEADBEEF, 2 cycles after the request edge.
REQ-032 Tie, PRIORITY_DATA=1: both request at the same edge -> data served first; instruction granted in the IDLE after data RESP; d_read_valid precedes i_read_valid.
REQ-033 Round-robin, PRIORITY_DATA=0: both requesters held continuously for 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-034 Write: d_write_enable=1, addr 0x200, data 0x12345678, wstrb 0b0011; memory ready after 3 cycles -> m_* fields stable throughout; d_write_ready pulses once; d_read_valid stays 0.
REQ-035 Timeout, TIMEOUT=4: memory never responds -> RESP after 4 BUSY cycles; bus_error=1 and i_read_valid=1 with data 0 in the same cycle; then IDLE.
REQ-036 Reset mid-BUSY: drive reset=0 while m_read_enable=1 -> all outputs 0 asynchronously; no valid pulse after release.
